// File: rtl/pluto_epp_pkg.sv
// Shared types and constants for the pluto EPP slave front end.
package pluto_epp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACT,
      ST_HOLD,
      ST_REL
   } epp_state_e;

   localparam int unsigned EPP_AW   = 5;
   localparam int unsigned RD_BYTES = 4;
   localparam int unsigned LANE_W   = $clog2(RD_BYTES);

   function automatic logic [7:0] byte_lane(input logic [8*RD_BYTES-1:0] word,
                                            input logic [LANE_W-1:0]     lane);
      logic [8*RD_BYTES-1:0] shifted;
      shifted = word >> {lane, 3'b000};
      return shifted[7:0];
   endfunction

endpackage

// File: rtl/pluto_epp_slave_if.sv
// EPP pad-side signal bundle; the host drives the strobes, the slave answers.
interface pluto_epp_slave_if;
   logic       nWrite;
   logic       nDataStr;
   logic       nAddrStr;
   logic [7:0] pport_din;
   logic [7:0] pport_dout;
   logic       pport_oe;
   logic       nWait;

   modport master (
      output nWrite, nDataStr, nAddrStr, pport_din,
      input  pport_dout, pport_oe, nWait
   );

   modport slave (
      input  nWrite, nDataStr, nAddrStr, pport_din,
      output pport_dout, pport_oe, nWait
   );
endinterface

// File: rtl/pluto_epp_slave_sync.sv
// Two-flop synchroniser with a registered previous value for rising-edge detection.
module epp_sync #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic d_i,
   output logic level_o,
   output logic rise_o
);

   logic [1:0] sync_q, sync_d;
   logic       prev_q, prev_d;

   always_comb begin
      sync_d = {sync_q[0], d_i};
      prev_d = sync_q[1];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= {2{RST_VAL}};
         prev_q <= RST_VAL;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign level_o = sync_q[1];
   assign rise_o  = sync_q[1] & ~prev_q;

endmodule

// File: rtl/pluto_epp_slave.sv
// EPP slave: strobe synchronisation, nWait handshake, auto-incrementing address,
// 16-bit write assembly and byte-serial readout of 32-bit read words.
module pluto_epp_slave
   import pluto_epp_pkg::*;
#(
   parameter int unsigned AW = EPP_AW
) (
   input  logic                 clk,
   input  logic                 reset,
   pluto_epp_slave_if.slave     epp,
   output logic                 wr_stb,
   output logic [AW-1:0]        wr_addr,
   output logic [7:0]           wr_byte,
   output logic [15:0]          wr_word,
   output logic                 rd_stb,
   output logic [AW-1:0]        rd_addr,
   input  logic [31:0]          rd_data
);

   logic ds_lvl, ds_rise, as_lvl, as_rise, rd_dir, dir_rise_unused;

   epp_sync #(.RST_VAL(1'b0)) u_sync_ds (
      .clk(clk), .reset(reset), .d_i(~epp.nDataStr), .level_o(ds_lvl), .rise_o(ds_rise)
   );
   epp_sync #(.RST_VAL(1'b0)) u_sync_as (
      .clk(clk), .reset(reset), .d_i(~epp.nAddrStr), .level_o(as_lvl), .rise_o(as_rise)
   );
   epp_sync #(.RST_VAL(1'b1)) u_sync_dir (
      .clk(clk), .reset(reset), .d_i(epp.nWrite), .level_o(rd_dir), .rise_o(dir_rise_unused)
   );

   logic active, strobe_edge;
   assign active = ds_lvl | as_lvl;
   // Edge of the combined strobe: some strobe rose and neither was already held.
   assign strobe_edge = (ds_rise | as_rise) & ~((ds_lvl & ~ds_rise) | (as_lvl & ~as_rise));

   epp_state_e       state_q, state_d;
   logic [AW-1:0]    addr_q, addr_d;
   logic [7:0]       lowbyte_q, lowbyte_d;
   logic [31:0]      rbuf_q, rbuf_d;
   logic [7:0]       out_byte_q, out_byte_d;
   logic             is_addr_q, is_addr_d;
   logic             is_read_q, is_read_d;
   logic [31:0]      rd_word;

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      lowbyte_d  = lowbyte_q;
      rbuf_d     = rbuf_q;
      out_byte_d = out_byte_q;
      is_addr_d  = is_addr_q;
      is_read_d  = is_read_q;
      wr_stb     = 1'b0;
      wr_byte    = '0;
      wr_word    = '0;
      rd_stb     = 1'b0;
      rd_word    = (addr_q[LANE_W-1:0] == '0) ? rd_data : rbuf_q;

      unique case (state_q)
         ST_IDLE: begin
            if (strobe_edge) begin
               state_d   = ST_ACT;
               is_addr_d = as_lvl;
               is_read_d = rd_dir;
            end
         end
         ST_ACT: begin
            state_d = ST_HOLD;
            if (is_addr_q) begin
               if (is_read_q) out_byte_d = 8'(addr_q);
               else           addr_d     = epp.pport_din[AW-1:0];
            end else if (!is_read_q) begin
               wr_stb    = 1'b1;
               wr_byte   = epp.pport_din;
               wr_word   = {epp.pport_din, lowbyte_q};
               lowbyte_d = epp.pport_din;
               addr_d    = addr_q + AW'(1);
            end else begin
               if (addr_q[LANE_W-1:0] == '0) begin
                  rd_stb = 1'b1;
                  rbuf_d = rd_data;
               end
               out_byte_d = byte_lane(rd_word, addr_q[LANE_W-1:0]);
               addr_d     = addr_q + AW'(1);
            end
         end
         ST_HOLD: begin
            if (!active) state_d = ST_REL;
         end
         ST_REL: begin
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         lowbyte_q  <= '0;
         rbuf_q     <= '0;
         out_byte_q <= '0;
         is_addr_q  <= 1'b0;
         is_read_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         lowbyte_q  <= lowbyte_d;
         rbuf_q     <= rbuf_d;
         out_byte_q <= out_byte_d;
         is_addr_q  <= is_addr_d;
         is_read_q  <= is_read_d;
      end
   end

   assign wr_addr        = addr_q;
   assign rd_addr        = addr_q;
   assign epp.pport_dout = out_byte_q;
   assign epp.pport_oe   = (state_q == ST_HOLD) && is_read_q;
   assign epp.nWait      = !((state_q == ST_HOLD) || (state_q == ST_REL));

endmodule

// File: doc/pluto_epp_slave.md
# pluto_epp_slave

Synchronous EPP (IEEE 1284 enhanced parallel port) slave front end for the pluto FPGA firmware; it sits directly upstream of the step/dout register file. It synchronises the host strobes and runs the nWait handshake. It also maintains the auto-incrementing address register and emits single-cycle write pulses with the assembled 16-bit word. On the read side, it captures 32-bit read words and serves them to the host one byte per strobe.

## Interface
- `AW`, default 5: address register width.
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  reset; synchronous, active-high.
- `nWrite`  in  1  EPP direction: 0 = host write, 1 = host read. Asynchronous to `clk`.
- `nDataStr`  in  1  EPP data strobe, active low. Asynchronous to `clk`.
- `nAddrStr`  in  1  EPP address strobe, active low. Asynchronous to `clk`.
- `pport_din`  in  8  parallel port data from the pad.
- `pport_dout`  out  8  data driven to the pad.
- `pport_oe`  out  1  pad output enable; the top level tristates the pad when this is 0.
- `nWait`  out  1  EPP wait, active low (0 = cycle acknowledged).
- `wr_stb`  out  1  one-cycle pulse on every host data write.
- `wr_addr`  out  AW  address of the write.
- `wr_byte`  out  8  byte written by the host.
- `wr_word`  out  16  `{wr_byte, previous lowbyte}`.
- `rd_stb`  out  1  one-cycle capture request on a data read with addr[1:0]==0.
- `rd_addr`  out  AW  address of the read.
- `rd_data`  in  32  read word; must be valid in the same cycle as `rd_stb`.

## Operation
- **Synchroniser:** `nWrite`, `nDataStr` and `nAddrStr` each pass through a 2-flop synchroniser. An active strobe is `~nDataStr | ~nAddrStr`.
  - An edge is a 0->1 transition of the synchronised active strobe.
  - If both strobes are active at the edge, the address strobe wins and no data action occurs.
- **FSM states:** IDLE, ACT, HOLD, REL.
  - IDLE -> ACT on an edge. ACT lasts one cycle, and all actions fire in ACT.
  - ACT -> HOLD unconditionally.
  - HOLD -> REL when the synchronised strobe is inactive.
  - REL -> IDLE after one cycle.
- **Address write** (ACT, address strobe, write): `addr <= pport_din[AW-1:0]`. No increment.
- **Address read** (ACT, address strobe, read): `out_byte <= {0, addr}`. No increment.
- **Data write** (ACT, data strobe, write):
  - Pulse `wr_stb` with `wr_addr=addr`, `wr_byte=pport_din` and `wr_word={pport_din, lowbyte}`.
  - Then `lowbyte <= pport_din` and `addr <= addr+1`.
- **Data read** (ACT, data strobe, read):
  - If addr[1:0]==0: pulse `rd_stb` and load `buf <= rd_data`, using `rd_data` in that same cycle.
  - `out_byte <= byte addr[1:0]` of the buffer. When addr[1:0]==0 this is byte 0 of the fresh `rd_data`.
  - Then `addr <= addr+1`.
- **Address wrap:** the address wraps modulo 2^AW, so 2^AW-1 increments to 0.
- **Pad drive:** `pport_dout=out_byte`. `pport_oe=1` only in HOLD when the latched direction is read.
- **nWait:** `nWait=0` in HOLD and REL, and 1 otherwise.

## Timing
- **Reset values:** `nWait=1`, `pport_oe=0`, `pport_dout=0`, `wr_stb=0`, `rd_stb=0`, `wr_addr=0`, `rd_addr=0`, `wr_byte=0`, `wr_word=0`. Internally, `addr=0`, `lowbyte=0`, `buf=0`, the synchronisers are inactive (1), and the FSM is in IDLE.
- **Strobe to action:** a strobe first sampled low at cycle 0 reaches the synchroniser output at cycle 1. ACT occurs at cycle 2, with `wr_stb`/`rd_stb` high during cycle 2.
- **Acknowledge:** `nWait` falls at cycle 3. Read data is valid on the pad from cycle 3.
- **Release:** a strobe released at cycle n (sampled) gives HOLD->REL at n+2 and `nWait=1` at n+3. `pport_oe` drops at n+2, which is before `nWait` rises.
- **No early edge:** a strobe that re-asserts while the FSM is in HOLD or REL is not treated as a new edge until the FSM is back in IDLE with the strobe seen inactive.
- **Reset mid-cycle:** `reset` asserted during any state returns the block to reset values on the next edge and releases the pad. The host cycle is abandoned and no pulse is emitted.

## Structure
- Package `pluto_epp_pkg` holds:
  - the FSM state enum (IDLE/ACT/HOLD/REL);
  - the default AW;
  - the byte-lane constant, 4 bytes per read word.
- Sub-module `epp_sync`: a 2-flop synchroniser with a registered previous value, giving a rising-edge output. It is instantiated once per strobe/direction input.

## Test plan
- **Address write:** write address 0x05 via `nAddrStr` -> no `wr_stb`; an address read then returns 0x05 on `pport_dout`.
- **Write pair:** address 0x00, then data writes 0x34 and 0x12 -> second `wr_stb` has `wr_addr=1`, `wr_word=0x1234`; the address is then 2.
- **Four-byte read:** address 0x00, `rd_data=0xDEADBEEF`, four data reads -> host sees EF, BE, AD, DE; `rd_stb` is high exactly once, on the first read.
- **Handshake timing:** strobe low at cycle 0 -> `wr_stb` at cycle 2 and `nWait=0` at cycle 3. Strobe release at n -> `nWait=1` at n+3, with `pport_oe=0` at least one cycle earlier.
- **Wrap and collision:** address 0x1F with one data write -> the address wraps to 0. Simultaneous `nAddrStr`/`nDataStr` with data 0x09 -> address becomes 0x09 and no `wr_stb`.
- **Reset in HOLD:** assert `reset` during HOLD of a read -> next cycle `nWait=1`, `pport_oe=0`, address 0.
